// File: rtl/arith_pkg.sv
// Shared types for the serial arithmetic blocks: FSM state encoding and digit-count helper.
// Reused by the serial subtractor and the planned serial adder.
package arith_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_t;

    // Guarded so a bad DIGIT reaches the top-level parameter check instead of a divide-by-zero.
    function automatic int digit_count(input int width, input int digit);
        return (digit > 0) ? (width / digit) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit underflows.
// Latency: combinational.
// Backpressure: none.
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial a - b - borrow_in, DIGIT bits per clock, LSB digit first.
// Latency: N_DIGITS edges from start acceptance to the done pulse.
// Backpressure: none; start is ignored (not queued) while busy.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int N_DIGITS = digit_count(WIDTH, DIGIT);
    localparam int CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_subtractor: DIGIT must be in 1..WIDTH and divide WIDTH");
    end

    fsm_state_t       state;
    fsm_state_t       state_nxt;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt;

    logic [DIGIT:0]   chain_b;
    logic [DIGIT-1:0] dig_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    last      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign chain_b[0] = borrow_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_subtractor_cell u_cell (
            .x    (a_sh[i]),
            .y    (b_sh[i]),
            .bin  (chain_b[i]),
            .d    (dig_d[i]),
            .bout (chain_b[i+1])
        );
    end

    // New digit enters at the MSB end; after N_DIGITS steps the first digit sits at bit 0.
    assign acc_nxt = (acc >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh       <= '0;
            b_sh       <= '0;
            acc        <= '0;
            borrow_q   <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b1;
            done       <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                a_sh     <= a;
                b_sh     <= b;
                borrow_q <= borrow_in;
                acc      <= '0;
                cnt      <= '0;
            end else if (step) begin
                a_sh     <= a_sh >> DIGIT;
                b_sh     <= b_sh >> DIGIT;
                borrow_q <= chain_b[DIGIT];
                acc      <= acc_nxt;
                cnt      <= cnt + CNT_W'(1);
            end
            // Result registers hold the previous answer through a following RUN.
            if (last) begin
                diff       <= acc_nxt;
                borrow_out <= chain_b[DIGIT];
                zero       <= (acc_nxt == '0);
            end
        end
    end

    assign busy = (state == ST_RUN);

endmodule
